// File: rtl/bf_mult_pkg.sv
// Shared types and helpers for the pipelined approximate floating-point multiplier.
package bf_mult_pkg;

  typedef enum logic [1:0] {
    PREC_AUTO = 2'd0,
    PREC_FULL = 2'd1,
    PREC_HALF = 2'd2,
    PREC_MIN  = 2'd3
  } prec_sel_e;

  typedef enum logic [1:0] {
    EXC_NONE,
    EXC_NAN,
    EXC_INF,
    EXC_ZERO
  } exc_e;

  typedef struct packed {
    logic nan;
    logic inf;
    logic ovf;
    logic udf;
  } flags_t;

  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Canonical quiet NaN: positive, all-ones exponent, only the top fraction bit set.
  function automatic logic [63:0] qnan(input int exp_w, input int man_w);
    logic [63:0] r;
    r = ((64'd1 << exp_w) - 64'd1) << man_w;
    r = r | (64'd1 << (man_w - 1));
    return r;
  endfunction

endpackage

// File: rtl/bf_mant_mask_mult.sv
// Masked mantissa multiply: precision mask, carry-save partial-product array, final CPA.
module bf_mant_mask_mult #(
  parameter  int MAN_W = 7,
  localparam int KW    = $clog2(MAN_W + 1),
  localparam int PW    = 2 * MAN_W + 2
) (
  input  logic [MAN_W:0]  man_a,
  input  logic [MAN_W:0]  man_b,
  input  logic [KW-1:0]   keep,
  output logic [PW-1:0]   prod
);

  logic [MAN_W:0] mask;
  logic [MAN_W:0] ma;
  logic [MAN_W:0] mb;
  logic [PW-1:0]  cs_sum;
  logic [PW-1:0]  cs_carry;
  logic [PW-1:0]  pp;
  logic [PW-1:0]  nsum;
  logic [PW-1:0]  ncarry;

  always_comb begin
    mask = '0;
    for (int j = 0; j < MAN_W; j++) begin
      mask[j] = (j >= MAN_W - int'(keep));
    end
    mask[MAN_W] = 1'b1;
  end

  assign ma = man_a & mask;
  assign mb = man_b & mask;

  // Carry-save accumulation; dropped carries above PW are multiples of 2**PW only.
  always_comb begin
    cs_sum   = '0;
    cs_carry = '0;
    pp       = '0;
    nsum     = '0;
    ncarry   = '0;
    for (int i = 0; i <= MAN_W; i++) begin
      pp       = ma[i] ? (PW'(mb) << i) : '0;
      nsum     = cs_sum ^ cs_carry ^ pp;
      ncarry   = ((cs_sum & cs_carry) | (cs_sum & pp) | (cs_carry & pp)) << 1;
      cs_sum   = nsum;
      cs_carry = ncarry;
    end
  end

  assign prod = cs_sum + cs_carry;

endmodule

// File: rtl/bf_approx_mult_pipe.sv
// Three-stage valid/ready floating-point multiplier with run-time precision control,
// exception flags and a saturating count of approximated results.
module bf_approx_mult_pipe #(
  parameter  int EXP_W     = 8,
  parameter  int MAN_W     = 7,
  parameter  int HALF_BITS = 3,
  parameter  int MIN_BITS  = 2,
  parameter  int AUTO_WIN  = 8,
  parameter  int CNT_W     = 16,
  localparam int W         = 1 + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [1:0]       prec_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     product,
  output logic [3:0]       flags,
  output logic [CNT_W-1:0] approx_cnt,
  input  logic             cnt_clr
);
  import bf_mult_pkg::*;

  localparam int                BIAS   = bias(EXP_W);
  localparam int                KW     = $clog2(MAN_W + 1);
  localparam int                PW     = 2 * MAN_W + 2;
  localparam int                EW     = EXP_W + 2;
  localparam logic [W-1:0]      QNAN   = W'(qnan(EXP_W, MAN_W));
  localparam logic signed [EW-1:0] EMAX_S = EW'((1 << EXP_W) - 1);

  // Reset asserts asynchronously and releases on a clock edge.
  logic [1:0] rst_sync;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

  logic v1, v2, v3;
  logic ld1, ld2, ld3;

  assign ld3      = !v3 || out_ready;
  assign ld2      = !v2 || ld3;
  assign ld1      = !v1 || ld2;
  assign in_ready = rst_int_n && ld1;

  logic               a_sign, b_sign;
  logic [EXP_W-1:0]   a_exp, b_exp;
  logic [MAN_W-1:0]   a_frac, b_frac;
  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  int                 dist_a, dist_b;
  logic [KW-1:0]      keep_d;
  exc_e               exc_d;

  assign {a_sign, a_exp, a_frac} = a;
  assign {b_sign, b_exp, b_frac} = b;
  assign a_zero = (a_exp == '0);
  assign b_zero = (b_exp == '0);
  assign a_inf  = (&a_exp) && (a_frac == '0);
  assign b_inf  = (&b_exp) && (b_frac == '0);
  assign a_nan  = (&a_exp) && (|a_frac);
  assign b_nan  = (&b_exp) && (|b_frac);

  always_comb begin
    dist_a = int'(a_exp) - BIAS;
    if (dist_a < 0) dist_a = -dist_a;
    dist_b = int'(b_exp) - BIAS;
    if (dist_b < 0) dist_b = -dist_b;
    keep_d = KW'(MAN_W);
    case (prec_sel_e'(prec_sel))
      PREC_FULL: keep_d = KW'(MAN_W);
      PREC_HALF: keep_d = KW'(HALF_BITS);
      PREC_MIN:  keep_d = KW'(MIN_BITS);
      PREC_AUTO: keep_d = (dist_a <= AUTO_WIN && dist_b <= AUTO_WIN) ? KW'(MAN_W) : KW'(HALF_BITS);
    endcase
    exc_d = EXC_NONE;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) exc_d = EXC_NAN;
    else if (a_inf || b_inf)                                     exc_d = EXC_INF;
    else if (a_zero || b_zero)                                   exc_d = EXC_ZERO;
  end

  logic             s1_sign, s1_approx;
  logic [EXP_W-1:0] s1_ea, s1_eb;
  logic [MAN_W:0]   s1_ma, s1_mb;
  logic [KW-1:0]    s1_keep;
  exc_e             s1_exc;

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      v1 <= 1'b0;  s1_sign <= 1'b0;  s1_approx <= 1'b0;
      s1_ea <= '0; s1_eb <= '0; s1_ma <= '0; s1_mb <= '0;
      s1_keep <= '0; s1_exc <= EXC_NONE;
    end else if (ld1) begin
      v1 <= in_valid;
      if (in_valid) begin
        s1_sign   <= a_sign ^ b_sign;
        s1_ea     <= a_exp;
        s1_eb     <= b_exp;
        s1_ma     <= a_zero ? '0 : {1'b1, a_frac};
        s1_mb     <= b_zero ? '0 : {1'b1, b_frac};
        s1_keep   <= keep_d;
        s1_approx <= (int'(keep_d) < MAN_W);
        s1_exc    <= exc_d;
      end
    end
  end

  logic [PW-1:0]          mant_prod;
  logic signed [EW-1:0]   exp_sum;

  bf_mant_mask_mult #(.MAN_W(MAN_W)) u_mant (
    .man_a (s1_ma),
    .man_b (s1_mb),
    .keep  (s1_keep),
    .prod  (mant_prod)
  );

  assign exp_sum = EW'(s1_ea) + EW'(s1_eb) - EW'(BIAS);

  logic                 s2_sign, s2_approx;
  logic signed [EW-1:0] s2_exp;
  logic [PW-1:0]        s2_prod;
  exc_e                 s2_exc;

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      v2 <= 1'b0; s2_sign <= 1'b0; s2_approx <= 1'b0;
      s2_exp <= '0; s2_prod <= '0; s2_exc <= EXC_NONE;
    end else if (ld2) begin
      v2 <= v1;
      if (v1) begin
        s2_sign   <= s1_sign;
        s2_approx <= s1_approx;
        s2_exp    <= exp_sum;
        s2_prod   <= mant_prod;
        s2_exc    <= s1_exc;
      end
    end
  end

  logic signed [EW-1:0] norm_exp;
  logic [MAN_W-1:0]     norm_frac;
  logic [W-1:0]         res_d;
  flags_t               flags_d;

  always_comb begin
    if (s2_prod[PW-1]) begin
      norm_exp  = s2_exp + EW'(1);
      norm_frac = s2_prod[PW-2 -: MAN_W];
    end else begin
      norm_exp  = s2_exp;
      norm_frac = s2_prod[PW-3 -: MAN_W];
    end
    res_d   = '0;
    flags_d = '0;
    case (s2_exc)
      EXC_NAN: begin
        res_d       = QNAN;
        flags_d.nan = 1'b1;
      end
      EXC_INF: begin
        res_d       = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        flags_d.inf = 1'b1;
      end
      EXC_ZERO: res_d = {s2_sign, {(W-1){1'b0}}};
      default: begin
        if (!norm_exp[EW-1] && norm_exp >= EMAX_S) begin
          res_d       = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          flags_d.ovf = 1'b1;
        end else if (norm_exp[EW-1] || norm_exp == '0) begin
          res_d       = {s2_sign, {(W-1){1'b0}}};
          flags_d.udf = 1'b1;
        end else begin
          res_d = {s2_sign, norm_exp[EXP_W-1:0], norm_frac};
        end
      end
    endcase
  end

  logic             s3_approx;
  logic [W-1:0]     product_q;
  flags_t           flags_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      v3 <= 1'b0; s3_approx <= 1'b0; product_q <= '0; flags_q <= '0;
    end else if (ld3) begin
      v3 <= v2;
      if (v2) begin
        s3_approx <= s2_approx;
        product_q <= res_d;
        flags_q   <= flags_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n)                                        cnt_q <= '0;
    else if (cnt_clr)                                      cnt_q <= '0;
    else if (v3 && out_ready && s3_approx && !(&cnt_q))    cnt_q <= cnt_q + CNT_W'(1);
  end

  assign out_valid  = v3;
  assign product    = product_q;
  assign flags      = flags_q;
  assign approx_cnt = cnt_q;

endmodule
